// File: rtl/sub_nbit_serial.sv
// Bit-serial N-bit subtractor (A - B - borrow-in), LSB first, one full-subtractor cell plus a borrow flop.
// Optional compare outputs o_zero/o_slt are compiled in when SUB_SERIAL_CMP_EN is defined.
module sub_nbit_serial #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_bor,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_bor,
  output logic                  o_ovf
`ifdef SUB_SERIAL_CMP_EN
  ,
  output logic                  o_zero,
  output logic                  o_slt
`endif
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
  logic [CW-1:0]         cnt_q;
  logic                  br_q;
  logic                  nz_q;
  logic                  rdy_q, vld_q, bor_q, ovf_q;
  logic                  bit_d, br_d;
`ifdef SUB_SERIAL_CMP_EN
  logic                  zero_q, slt_q;
`endif

  // Single full-subtractor cell operating on the current LSBs.
  always_comb begin
    bit_d = a_q[0] ^ b_q[0] ^ br_q;
    br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      nz_q    <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      bor_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SUB_SERIAL_CMP_EN
      zero_q  <= 1'b0;
      slt_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_vld) begin
            a_q     <= i_num_a;
            b_q     <= i_num_b;
            br_q    <= i_bor;
            cnt_q   <= '0;
            nz_q    <= 1'b0;
            rdy_q   <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= {bit_d, res_q[DATA_WIDTH-1:1]};
          br_q  <= br_d;
          nz_q  <= nz_q | bit_d;
          cnt_q <= cnt_q + CW'(1);
          // On the MSB edge br_q is the borrow into the sign cell.
          if (cnt_q == LAST) begin
            state_q <= DONE;
            vld_q   <= 1'b1;
            bor_q   <= br_d;
            ovf_q   <= br_q ^ br_d;
`ifdef SUB_SERIAL_CMP_EN
            zero_q  <= ~(nz_q | bit_d);
            slt_q   <= bit_d ^ (br_q ^ br_d);
`endif
          end
        end
        DONE: begin
          if (i_rdy) begin
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_rdy = rdy_q;
  assign o_vld = vld_q;
  assign o_res = res_q;
  assign o_bor = bor_q;
  assign o_ovf = ovf_q;
`ifdef SUB_SERIAL_CMP_EN
  assign o_zero = zero_q;
  assign o_slt  = slt_q;
`endif

endmodule

// File: tb/tb_sub_nbit_serial.sv
// Scoreboard bench for sub_nbit_serial: stimulus pushes arithmetic-model results, a monitor pops on o_vld.
// Compare outputs are checked when SUB_SERIAL_CMP_EN is defined.
module tb_sub_nbit_serial;
  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_vld = 1'b0;
  logic         o_rdy;
  logic [W-1:0] i_num_a = '0;
  logic [W-1:0] i_num_b = '0;
  logic         i_bor = 1'b0;
  logic         o_vld;
  logic         i_rdy = 1'b1;
  logic [W-1:0] o_res;
  logic         o_bor;
  logic         o_ovf;
`ifdef SUB_SERIAL_CMP_EN
  logic         o_zero;
  logic         o_slt;
`endif

  sub_nbit_serial #(.DATA_WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .o_rdy(o_rdy),
    .i_num_a(i_num_a), .i_num_b(i_num_b), .i_bor(i_bor),
    .o_vld(o_vld), .i_rdy(i_rdy), .o_res(o_res), .o_bor(o_bor), .o_ovf(o_ovf)
`ifdef SUB_SERIAL_CMP_EN
    , .o_zero(o_zero), .o_slt(o_slt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [W-1:0] res;
    logic         bor;
    logic         ovf;
    logic         zero;
    logic         slt;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bor, input int acc);
    exp_t   e;
    longint ua, ub, d, sa, sb_v, sv, lo, hi;
    ua   = longint'(a);
    ub   = longint'(b);
    d    = ua - ub - longint'(bor);
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    sv   = sa - sb_v - longint'(bor);
    lo   = -(longint'(1) << (W - 1));
    hi   = (longint'(1) << (W - 1)) - 1;
    e.res  = W'(d);
    e.bor  = (d < 0);
    e.ovf  = (sv < lo) || (sv > hi);
    e.zero = (e.res == '0);
    e.slt  = (sv < 0);
    e.acc  = acc;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bor, output int acc);
    int n;
    @(negedge i_clk);
    i_vld = 1'b1; i_num_a = a; i_num_b = b; i_bor = bor;
    n = 0;
    while (!o_rdy && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 64'(n), 64'(0));
      acc = -1;
    end else begin
      acc = cyc + 1;
      sb.push_back(model(a, b, bor, acc));
    end
    @(negedge i_clk);
    i_vld = 1'b0;
    i_num_a = W'($urandom); i_num_b = W'($urandom); i_bor = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || o_vld) && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", 64'(n), 64'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"}, 64'(o_rdy), 64'(1));
    chk({tag, "_vld"}, 64'(o_vld), 64'(0));
    chk({tag, "_res"}, 64'(o_res), 64'(0));
    chk({tag, "_bor"}, 64'(o_bor), 64'(0));
    chk({tag, "_ovf"}, 64'(o_ovf), 64'(0));
`ifdef SUB_SERIAL_CMP_EN
    chk({tag, "_zero"}, 64'(o_zero), 64'(0));
    chk({tag, "_slt"}, 64'(o_slt), 64'(0));
`endif
  endtask

  // Monitor: pops on o_vld rising, re-checks held outputs every cycle while o_vld stays high.
  initial begin
    exp_t cur;
    bit   prev_vld;
    bit   have;
    prev_vld = 1'b0;
    have = 1'b0;
    forever begin
      @(posedge i_clk);
      cyc++;
      #1;
      if (i_rst) begin
        prev_vld = 1'b0;
        have = 1'b0;
      end else begin
        if (o_vld && !prev_vld) begin
          if (sb.size() == 0) begin
            chk("unexpected_vld", 64'(o_vld), 64'(0));
            have = 1'b0;
          end else begin
            cur = sb.pop_front();
            have = 1'b1;
            chk("latency", 64'(cyc - cur.acc), 64'(W));
          end
        end
        if (o_vld && have) begin
          chk("res", 64'(o_res), 64'(cur.res));
          chk("bor", 64'(o_bor), 64'(cur.bor));
          chk("ovf", 64'(o_ovf), 64'(cur.ovf));
          chk("rdy_low_in_done", 64'(o_rdy), 64'(0));
`ifdef SUB_SERIAL_CMP_EN
          chk("zero", 64'(o_zero), 64'(cur.zero));
          chk("slt", 64'(o_slt), 64'(cur.slt));
`endif
        end
        if (!o_vld && prev_vld) chk("rdy_after_hs", 64'(o_rdy), 64'(1));
        prev_vld = o_vld;
      end
    end
  end

  initial begin
    forever begin
      @(negedge i_clk);
      if (rand_rdy) i_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int acc1, acc2;
    i_rst = 1'b1;
    #12;
    check_reset_vals("rst_init");
    @(negedge i_clk);
    i_rst = 1'b0;
    i_rdy = 1'b1;

    issue(8'h05, 8'h03, 1'b0, acc1);
    issue(8'h00, 8'h01, 1'b0, acc1);
    issue(8'h80, 8'h01, 1'b0, acc1);
    issue(8'h10, 8'h0F, 1'b1, acc1);
    drain();

    // Back-pressure with junk on the inputs during CALC and DONE.
    i_rdy = 1'b0;
    issue(8'h5A, 8'h3C, 1'b1, acc1);
    begin
      int n;
      n = 0;
      while (!o_vld && n < 50) begin
        @(negedge i_clk);
        i_vld = 1'($urandom); i_num_a = W'($urandom); i_num_b = W'($urandom); i_bor = 1'($urandom);
        n++;
      end
      if (n >= 50) chk("vld_timeout", 64'(n), 64'(0));
    end
    repeat (5) begin
      @(negedge i_clk);
      i_vld = 1'($urandom); i_num_a = W'($urandom); i_num_b = W'($urandom); i_bor = 1'($urandom);
    end
    i_vld = 1'b0;
    i_rdy = 1'b1;
    drain();

    issue(8'hC3, 8'h3C, 1'b0, acc1);
    issue(8'h7F, 8'hFF, 1'b1, acc2);
    chk("spacing", 64'(acc2 - acc1), 64'(W + 2));
    drain();

    // Reset while bit 4 is being computed.
    issue(8'h55, 8'h22, 1'b0, acc1);
    repeat (4) @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_vals("rst_calc");
    sb.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    issue(8'h03, 8'h05, 1'b0, acc1);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), acc1);
    end
    rand_rdy = 1'b0;
    @(negedge i_clk);
    i_rdy = 1'b1;
    drain();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
